// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between two byte producers (A, B),
// each buffered by its own byte FIFO.

module uart_tx_arbiter_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic       i_Clk,
  input  logic       rst,
  input  logic       wr_i,
  input  logic [7:0] data_i,
  input  logic       pop_i,
  output logic [7:0] head_c_o,
  output logic       empty_o,
  output logic       full_o,
  output logic       ovf_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             ovf_q, ovf_d;
  logic             push_c;
  logic             pop_c;

  // Full decision uses the pre-edge count, so a same-edge pop never rescues a write.
  always_comb begin
    push_c   = wr_i & ~full_q;
    pop_c    = pop_i & ~empty_q;
    wr_ptr_d = wr_ptr_q + PTR_W'(push_c);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_c);
    cnt_d    = cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
    empty_d  = (cnt_d == '0);
    full_d   = (cnt_d == CNT_W'(DEPTH));
    ovf_d    = ovf_q | (wr_i & full_q);
  end

  always_ff @(posedge i_Clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge i_Clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
    end
  end

  assign head_c_o = mem_q[rd_ptr_q];
  assign empty_o  = empty_q;
  assign full_o   = full_q;
  assign ovf_o    = ovf_q;

endmodule

module uart_tx_arbiter #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned ACT_TIMEOUT = 4
) (
  input  logic       i_Clk,
  input  logic       rst,
  input  logic       i_A_DV,
  input  logic [7:0] i_A_Byte,
  output logic       o_A_Full,
  output logic       o_A_Ovf,
  input  logic       i_B_DV,
  input  logic [7:0] i_B_Byte,
  output logic       o_B_Full,
  output logic       o_B_Ovf,
  output logic       o_Tx_DV,
  output logic [7:0] o_Tx_Byte,
  input  logic       i_Tx_Active,
  input  logic       i_Tx_Done,
  output logic       o_Grant,
  output logic       o_Busy
);

  localparam int unsigned TMO_W = (ACT_TIMEOUT > 1) ? $clog2(ACT_TIMEOUT) : 1;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_LAUNCH    = 2'd1;
  localparam logic [1:0] ST_WAIT_ACT  = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [7:0]       byte_q, byte_d;
  logic             grant_q, grant_d;
  logic             dv_q, dv_d;
  logic             busy_q, busy_d;

  logic             pop_a_c, pop_b_c, pick_b_c;
  logic [7:0]       a_head_c, b_head_c;
  logic             a_empty, b_empty;

  uart_tx_arbiter_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_a (
    .i_Clk    (i_Clk),
    .rst      (rst),
    .wr_i     (i_A_DV),
    .data_i   (i_A_Byte),
    .pop_i    (pop_a_c),
    .head_c_o (a_head_c),
    .empty_o  (a_empty),
    .full_o   (o_A_Full),
    .ovf_o    (o_A_Ovf)
  );

  uart_tx_arbiter_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_b (
    .i_Clk    (i_Clk),
    .rst      (rst),
    .wr_i     (i_B_DV),
    .data_i   (i_B_Byte),
    .pop_i    (pop_b_c),
    .head_c_o (b_head_c),
    .empty_o  (b_empty),
    .full_o   (o_B_Full),
    .ovf_o    (o_B_Ovf)
  );

  // Next-state: IDLE arbitrates and pops; a still-active transmitter blocks new launches.
  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    byte_d   = byte_q;
    grant_d  = grant_q;
    pop_a_c  = 1'b0;
    pop_b_c  = 1'b0;
    pick_b_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!i_Tx_Active && (!a_empty || !b_empty)) begin
          if (a_empty) begin
            pick_b_c = 1'b1;
          end else if (b_empty) begin
            pick_b_c = 1'b0;
          end else begin
            pick_b_c = ~grant_q;
          end
          pop_a_c = ~pick_b_c;
          pop_b_c = pick_b_c;
          byte_d  = pick_b_c ? b_head_c : a_head_c;
          grant_d = pick_b_c;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        tmo_d   = '0;
        state_d = ST_WAIT_ACT;
      end
      ST_WAIT_ACT: begin
        // An early Done wins over Active; a silent transmitter drops the byte.
        if (i_Tx_Done) begin
          state_d = ST_IDLE;
        end else if (i_Tx_Active) begin
          state_d = ST_WAIT_DONE;
        end else if (tmo_q == TMO_W'(ACT_TIMEOUT - 1)) begin
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (i_Tx_Done) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    dv_d   = (state_d == ST_LAUNCH);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_Clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      tmo_q   <= '0;
      byte_q  <= 8'h00;
      grant_q <= 1'b0;
      dv_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      byte_q  <= byte_d;
      grant_q <= grant_d;
      dv_q    <= dv_d;
      busy_q  <= busy_d;
    end
  end

  assign o_Tx_DV   = dv_q;
  assign o_Tx_Byte = byte_q;
  assign o_Grant   = grant_q;
  assign o_Busy    = busy_q;

endmodule
